// File: rtl/pokey_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// pokey_bus_arbiter_if
//   Bundles the two requester handshakes and the POKEY register bus that the
//   pokey_bus_arbiter sits on.
//
//   Requester side : req0/rw0/addr0/wdata0/ack0, req1/rw1/addr1/wdata1/ack1,
//                    shared rdata
//   POKEY side     : pokey_din, pokey_dout, pokey_a, pokey_phi2, pokey_rw,
//                    pokey_cs0_bar
//   Status         : busy, init_done
//
//   Modports
//     slave  - the arbiter (takes requests and POKEY Dout, drives the bus)
//     master - the surrounding system (requesters plus the POKEY instance)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface pokey_bus_arbiter_if;
  logic       req0;
  logic       rw0;
  logic [3:0] addr0;
  logic [7:0] wdata0;
  logic       ack0;
  logic       req1;
  logic       rw1;
  logic [3:0] addr1;
  logic [7:0] wdata1;
  logic       ack1;
  logic [7:0] rdata;
  logic [7:0] pokey_din;
  logic [7:0] pokey_dout;
  logic [3:0] pokey_a;
  logic       pokey_phi2;
  logic       pokey_rw;
  logic       pokey_cs0_bar;
  logic       busy;
  logic       init_done;

  modport slave (
    input  req0, rw0, addr0, wdata0,
    input  req1, rw1, addr1, wdata1,
    input  pokey_dout,
    output ack0, ack1, rdata,
    output pokey_din, pokey_a, pokey_phi2, pokey_rw, pokey_cs0_bar,
    output busy, init_done
  );

  modport master (
    output req0, rw0, addr0, wdata0,
    output req1, rw1, addr1, wdata1,
    output pokey_dout,
    input  ack0, ack1, rdata,
    input  pokey_din, pokey_a, pokey_phi2, pokey_rw, pokey_cs0_bar,
    input  busy, init_done
  );
endinterface

// File: rtl/pokey_bus_arbiter.sv
// ---------------------------------------------------------------------------
// pokey_bus_arbiter
//   Shares one POKEY register bus between two requesters with round-robin
//   arbitration. Every granted request becomes one complete POKEY bus cycle
//   (setup with phi2 low, phi2 strobe, hold with the ack pulse). After clr the
//   arbiter first writes SKCTL (address F) and then AUDCTL (address 8) so that
//   POKEY leaves its cleared state before any requester is served.
//
//   Ports
//     clk  - 100 MHz system clock
//     clr  - synchronous active-high reset
//     bus  - pokey_bus_arbiter_if.slave: requester handshakes, POKEY bus,
//            busy / init_done status. All outputs are registered.
//
//   Parameters
//     SETUP_CYC   (1-15) cycles of address/data setup with phi2 low
//     PHI2_HIGH   (2-15) cycles phi2 is held high
//     INIT_SKCTL  value written to address F after reset
//     INIT_AUDCTL value written to address 8 after the SKCTL write
//
//   Optional feature: define POKEY_ARB_SHADOW_EN to keep a shadow copy of the
//   write-only registers 0-7 and F; reads of those addresses are then answered
//   from the shadow in one cycle without touching the POKEY bus.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module pokey_bus_arbiter #(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned PHI2_HIGH   = 4,
  parameter logic [7:0]  INIT_SKCTL  = 8'h03,
  parameter logic [7:0]  INIT_AUDCTL = 8'h00
) (
  input logic                clk,
  input logic                clr,
  pokey_bus_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    INIT_SK = 3'd0,
    INIT_AC = 3'd1,
    IDLE    = 3'd2,
    SETUP   = 3'd3,
    STROBE  = 3'd4,
    HOLD    = 3'd5
  } state_t;

  localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LAST = 4'(PHI2_HIGH - 1);

  state_t     state_r;
  state_t     nextState_s;
  logic [3:0] phase_r;
  logic       lastGrant_r;   // requester of the most recent grant
  logic       initStage_r;   // 0: SKCTL write in progress, 1: AUDCTL write
  logic       initDone_r;
  logic       bypass_r;      // current access is served from the shadow

  logic       grantValid_s;
  logic       grantSel_s;
  logic       selRw_s;
  logic [3:0] selAddr_s;
  logic [7:0] selData_s;
  logic       bypass_s;
  logic       bypassNext_s;
  logic       ackSel_s;

  logic       phi2_r, cs0Bar_r, rw_r, ack0_r, ack1_r, busy_r;
  logic [3:0] a_r;
  logic [7:0] din_r, rdata_r;

  logic       phi2_s, cs0Bar_s, rw_s, ack0_s, ack1_s, busy_s;
  logic [3:0] a_s;
  logic [7:0] din_s, rdata_s;

`ifdef POKEY_ARB_SHADOW_EN
  logic [7:0] shadow_r [0:8];

  // Write-only registers that the shadow mirrors: 0-7 and F.
  function automatic logic isShadowAddr(input logic [3:0] addr);
    return (addr[3] == 1'b0) || (addr == 4'hF);
  endfunction

  // Shadow slot for an address: 0-7 map directly, F uses slot 8.
  function automatic logic [3:0] shadowIdx(input logic [3:0] addr);
    return (addr == 4'hF) ? 4'd8 : {1'b0, addr[2:0]};
  endfunction
`endif

  // Round-robin request selection, only evaluated in IDLE after init.
  always_comb begin
    grantValid_s = 1'b0;
    grantSel_s   = 1'b0;
    if ((state_r == IDLE) && initDone_r) begin
      if (bus.req0 && bus.req1) begin
        grantValid_s = 1'b1;
        grantSel_s   = ~lastGrant_r;
      end else if (bus.req0) begin
        grantValid_s = 1'b1;
        grantSel_s   = 1'b0;
      end else if (bus.req1) begin
        grantValid_s = 1'b1;
        grantSel_s   = 1'b1;
      end else begin
        grantValid_s = 1'b0;
        grantSel_s   = 1'b0;
      end
    end else begin
      grantValid_s = 1'b0;
      grantSel_s   = 1'b0;
    end
    selRw_s   = grantSel_s ? bus.rw1    : bus.rw0;
    selAddr_s = grantSel_s ? bus.addr1  : bus.addr0;
    selData_s = grantSel_s ? bus.wdata1 : bus.wdata0;
`ifdef POKEY_ARB_SHADOW_EN
    bypass_s  = grantValid_s && selRw_s && isShadowAddr(selAddr_s);
`else
    bypass_s  = 1'b0;
`endif
  end

  // FSM state register and phase counter (restarts on every state change).
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r <= INIT_SK;
      phase_r <= 4'd0;
    end else begin
      state_r <= nextState_s;
      phase_r <= (nextState_s != state_r) ? 4'd0 : (phase_r + 4'd1);
    end
  end

  // FSM next-state logic.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      INIT_SK: nextState_s = SETUP;
      INIT_AC: nextState_s = SETUP;
      IDLE: begin
        if (grantValid_s) begin
          nextState_s = bypass_s ? HOLD : SETUP;
        end else begin
          nextState_s = IDLE;
        end
      end
      SETUP:   nextState_s = (phase_r == SETUP_LAST)  ? STROBE : SETUP;
      STROBE:  nextState_s = (phase_r == STROBE_LAST) ? HOLD   : STROBE;
      HOLD: begin
        // After the SKCTL write the AUDCTL write follows; otherwise go idle.
        if (!initDone_r && !initStage_r) begin
          nextState_s = INIT_AC;
        end else begin
          nextState_s = IDLE;
        end
      end
      default: nextState_s = INIT_SK;
    endcase
  end

  // FSM output logic: next values for the registered outputs.
  always_comb begin
    if (state_r == IDLE) begin
      bypassNext_s = bypass_s;
    end else if ((state_r == INIT_SK) || (state_r == INIT_AC)) begin
      bypassNext_s = 1'b0;
    end else begin
      bypassNext_s = bypass_r;
    end

    // lastGrant_r only reflects a grant from the following cycle on.
    ackSel_s = (state_r == IDLE) ? grantSel_s : lastGrant_r;

    phi2_s   = (nextState_s == STROBE);
    cs0Bar_s = !(((nextState_s == SETUP) || (nextState_s == STROBE) ||
                  (nextState_s == HOLD)) && !bypassNext_s);
    ack0_s   = (nextState_s == HOLD) && (state_r != HOLD) && initDone_r && !ackSel_s;
    ack1_s   = (nextState_s == HOLD) && (state_r != HOLD) && initDone_r &&  ackSel_s;
    busy_s   = (nextState_s != IDLE);

    // Command is latched when it is issued and held for the whole cycle.
    if ((state_r == IDLE) && grantValid_s) begin
      a_s   = selAddr_s;
      din_s = selData_s;
      rw_s  = selRw_s;
    end else if (state_r == INIT_SK) begin
      a_s   = 4'hF;
      din_s = INIT_SKCTL;
      rw_s  = 1'b0;
    end else if (state_r == INIT_AC) begin
      a_s   = 4'h8;
      din_s = INIT_AUDCTL;
      rw_s  = 1'b0;
    end else if ((nextState_s == IDLE) || (nextState_s == INIT_AC) ||
                 (nextState_s == INIT_SK)) begin
      a_s   = a_r;
      din_s = din_r;
      rw_s  = 1'b1;
    end else begin
      a_s   = a_r;
      din_s = din_r;
      rw_s  = rw_r;
    end

    // Read data is sampled on the last phi2-high cycle.
    if ((state_r == STROBE) && (nextState_s == HOLD) && rw_r) begin
      rdata_s = bus.pokey_dout;
    end
`ifdef POKEY_ARB_SHADOW_EN
    else if ((state_r == IDLE) && bypass_s) begin
      rdata_s = shadow_r[shadowIdx(selAddr_s)];
    end
`endif
    else begin
      rdata_s = rdata_r;
    end
  end

  // Output, grant-history and init-progress registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      phi2_r      <= 1'b0;
      cs0Bar_r    <= 1'b1;
      rw_r        <= 1'b1;
      a_r         <= 4'h0;
      din_r       <= 8'h00;
      ack0_r      <= 1'b0;
      ack1_r      <= 1'b0;
      rdata_r     <= 8'h00;
      busy_r      <= 1'b1;
      lastGrant_r <= 1'b1;
      initStage_r <= 1'b0;
      initDone_r  <= 1'b0;
      bypass_r    <= 1'b0;
    end else begin
      phi2_r   <= phi2_s;
      cs0Bar_r <= cs0Bar_s;
      rw_r     <= rw_s;
      a_r      <= a_s;
      din_r    <= din_s;
      ack0_r   <= ack0_s;
      ack1_r   <= ack1_s;
      rdata_r  <= rdata_s;
      busy_r   <= busy_s;
      bypass_r <= bypassNext_s;
      if (grantValid_s) begin
        lastGrant_r <= grantSel_s;
      end
      if ((state_r == HOLD) && (nextState_s == INIT_AC)) begin
        initStage_r <= 1'b1;
      end
      if ((state_r == HOLD) && !initDone_r && initStage_r) begin
        initDone_r <= 1'b1;
      end
    end
  end

`ifdef POKEY_ARB_SHADOW_EN
  // Shadow copy, updated when a write (bus or init) reaches its hold cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 9; i++) begin
        shadow_r[i] <= 8'h00;
      end
    end else if ((state_r == STROBE) && (nextState_s == HOLD) && !rw_r &&
                 isShadowAddr(a_r)) begin
      shadow_r[shadowIdx(a_r)] <= din_r;
    end
  end
`endif

  assign bus.pokey_phi2    = phi2_r;
  assign bus.pokey_cs0_bar = cs0Bar_r;
  assign bus.pokey_rw      = rw_r;
  assign bus.pokey_a       = a_r;
  assign bus.pokey_din     = din_r;
  assign bus.ack0          = ack0_r;
  assign bus.ack1          = ack1_r;
  assign bus.rdata         = rdata_r;
  assign bus.busy          = busy_r;
  assign bus.init_done     = initDone_r;

endmodule

// File: doc/pokey_bus_arbiter.md
Name: pokey_bus_arbiter

Overview:
- Shares one POKEY register bus between two requesters, e.g. the CPU bus bridge and a sound-effect sequencer.
- Round-robin arbitration; each granted request becomes one complete POKEY bus cycle on Din/A/phi2/readHighWriteLow/cs0Bar.
- After reset it runs an init sequence (SKCTL then AUDCTL) so POKEY leaves its skCtl-cleared state before any requester is served.
- Sits between the system bus logic and the POKEY instance, all on the 100 MHz clk.

Parameters:
- SETUP_CYC, 2: cycles A/Din/rw/cs0Bar are valid with phi2 low before the strobe (range 1-15).
- PHI2_HIGH, 4: cycles phi2 is held high (range 2-15). Must be at least 2 so POKEY dataOut has settled when sampled.
- INIT_SKCTL, 8'h03: value written to address F after reset.
- INIT_AUDCTL, 8'h00: value written to address 8 after the SKCTL write.

Ports:
- clk  in  1  system clock.
- clr  in  1  reset; synchronous, active-high.
- req0  in  1  requester 0 request; held high with command stable until ack0.
- rw0  in  1  requester 0 direction: 1 = read, 0 = write.
- addr0  in  4  requester 0 POKEY register address.
- wdata0  in  8  requester 0 write data.
- ack0  out  1  one-cycle completion pulse to requester 0.
- req1, rw1, addr1, wdata1, ack1: same as above, for requester 1.
- rdata  out  8  read result; valid in the ack cycle, held until the next read completes.
- pokey_din  out  8  drives POKEY Din.
- pokey_dout  in  8  POKEY Dout.
- pokey_a  out  4  POKEY A.
- pokey_phi2  out  1  POKEY phi2.
- pokey_rw  out  1  POKEY readHighWriteLow.
- pokey_cs0_bar  out  1  POKEY cs0Bar.
- busy  out  1  high whenever the FSM is not in IDLE.
- init_done  out  1  high once the init writes are complete; stays high until clr.

Behaviour:
- All outputs are registered.
- Reset values: pokey_phi2=0, pokey_cs0_bar=1, pokey_rw=1, pokey_a=0, pokey_din=0, ack0=ack1=0, rdata=0, init_done=0, busy=1, last_grant=1 (so requester 0 wins the first tie).
- FSM states: INIT_SK, INIT_AC, IDLE, SETUP, STROBE, HOLD. A 4-bit phase counter times SETUP and STROBE.
- Bus cycle (cycle 0 = the IDLE cycle that grants):
  - Cycle 0: command latched.
  - Cycles 1..SETUP_CYC: SETUP. A/din/rw driven, cs0_bar=0, phi2=0.
  - Next PHI2_HIGH cycles: STROBE. phi2=1; A/din/rw/cs0_bar unchanged.
  - Next cycle: HOLD. phi2=0, cs0_bar=0, ack of the granted requester =1. For reads, rdata takes the pokey_dout sampled on the last STROBE cycle.
  - Next cycle: IDLE. cs0_bar=1, rw=1.
  - With defaults, ack arrives at cycle 7 and the next grant is possible at cycle 8.
- Init sequence: after clr the FSM goes to INIT_SK and runs a full write cycle (A=F, din=INIT_SKCTL), then INIT_AC (A=8, din=INIT_AUDCTL), then IDLE with init_done=1.
  - Init cycles raise no ack.
  - Requests are ignored until init_done=1.
  - If INIT_SKCTL[1:0]==0, POKEY stays cleared and drops the AUDCTL write. The arbiter still completes both writes and sets init_done.
- Arbitration happens only in IDLE.
  - One req high: grant it.
  - Both high: grant the requester that is not last_grant.
  - last_grant updates on every grant.
- Requests that arrive while busy wait for IDLE.
- The command is latched at grant, so addr/data changes after grant are ignored.
- Requester dropping req mid-cycle: the cycle still completes and ack still pulses.
- Requester must drop req on the edge after seeing ack. If req is still high in the following IDLE, it is a new request.
- ack0 and ack1 are never high in the same cycle.
- clr mid-cycle: everything returns to reset values on the next edge, the FSM restarts init, and no ack is issued for the aborted cycle.
- Read addresses other than 8/A are passed to the bus unchanged; POKEY returns its stale dataOut.

Optional Feature:
- Macro POKEY_ARB_SHADOW_EN.
- Defined:
  - A 9x8 shadow holds the last data written to addresses 0-7 and F. Bus writes and init writes update it; shadow reset value is 0.
  - Reads of addresses 0-7 or F bypass the bus: no SETUP/STROBE, pokey_cs0_bar stays 1, ack and rdata=shadow occur in cycle 1, and the FSM is back in IDLE in cycle 2.
  - Reads of all other addresses use the normal bus cycle.
- Not defined: no shadow storage; every access runs a bus cycle.

Test Plan:
- Release clr, no requests → write to A=F/din=03 then A=8/din=00, each phi2 high 4 cycles; init_done rises on cycle 16 after reset; no ack pulses.
- After init, req0 writes addr=0 data=0x55 → cs0_bar low cycles 1-7, phi2 high cycles 3-6, ack0 in cycle 7, POKEY audf1=0x55.
- req0 and req1 raised in the same cycle, both held → grants alternate, requester 0 first (last_grant=1 after reset); acks on cycles 7 and 15.
- req1 reads addr=A with pokey_dout=0xC3 during STROBE → rdata=0xC3 at ack1, held through a subsequent write.
- clr asserted during STROBE of a req0 write → next cycle phi2=0, cs0_bar=1; no ack0; init sequence reruns.
- With POKEY_ARB_SHADOW_EN: write addr=3 data=0xA7, then read addr=3 → ack in cycle 1, rdata=0xA7, pokey_cs0_bar stays 1. Without the macro, the same read takes a full 7-cycle bus cycle.
